id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the MIPS pipeline: consumes the fetched instruction word and its PC+4 from the fetch stage and owns the 32×32 register file. It decodes control fields, reads operands, sign-extends immediates and computes the branch target. All of these land in the ID/EX pipeline register feeding EX. It also detects load-use hazards, emitting a stall request and a bubble, and honours a flush from EX on a taken branch.

## Interface
Parameters:
- REG_COUNT, 32, register-file depth; register 0 is hardwired to zero.
- DATA_W, 32, data and instruction width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  asynchronous, active-high reset.
- Ins  in  32  instruction word from fetch.
- nextPC  in  32  PC+4 of Ins.
- flush  in  1  from EX; taken branch, so discard the decode in progress.
- W_en  in  1  write-back enable.
- W_addr  in  5  write-back register.
- W_data  in  32  write-back data.
- stall  out  1  combinational; fetch must hold PC, Ins and nextPC for the next cycle.
- rs_data, rt_data  out  32  registered operands.
- imm_ext  out  32  registered sign-extended Ins[15:0].
- br_target  out  32  registered nextPC + (imm_ext << 2), modulo 2^32.
- dest  out  5  registered destination register.
- pc4_out  out  32  registered nextPC.
- alu_op  out  3  registered: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT.
- alu_src, reg_write, mem_read, mem_write, branch  out  1 each  registered control.
- illegal  out  1  registered; the instruction was unsupported.

## Operation
Decode, by opcode Ins[31:26]:
- 000000 R-type, using funct Ins[5:0]:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Sets reg_write=1 and dest=rd.
  - Any other funct is illegal.
- 001000 addi: alu_src=1, reg_write=1, dest=rt, ADD.
- 100011 lw: alu_src=1, mem_read=1, reg_write=1, dest=rt, ADD.
- 101011 sw: alu_src=1, mem_write=1, dest=0, ADD.
- 000100 beq: branch=1, SUB, dest=0.
- Any other opcode: illegal=1; all control 0; dest=0; ALU ADD.

Register file:
- Read addresses are rs=Ins[25:21] and rt=Ins[20:16]. Reads of register 0 return 0.
- Write-back occurs on posedge when W_en=1 and W_addr≠0. Writes to register 0 are dropped.
- Same-cycle bypass: if W_en=1, W_addr≠0 and W_addr equals rs (or rt), the operand captured this edge is W_data, not the old contents.

Hazard detection:
- stall = ex_mem_read & (ex_dest≠0) & (ex_dest==rs | (ex_dest==rt & Ins uses rt)). Here ex_mem_read and ex_dest are the current ID/EX register outputs.
- An instruction uses rt if it is an R-type, sw or beq.
- A stall cycle loads a bubble (all control 0, dest=0, illegal=0) into ID/EX. Upstream re-presents the same Ins on the following cycle.

Flush:
- flush=1 loads a bubble regardless of Ins.
- flush takes priority over stall. stall is forced to 0 while flush=1.

Reset:
- Every registered output goes to 0 and stall=0.
- All registers in the register file clear to 0.
- Release is synchronous to the next posedge. No partially decoded state survives reset.

## Timing
- Latency is 1 cycle: Ins presented before edge N appears decoded on outputs after edge N.
- Register-file write and ID/EX capture share the same edge. The bypass removes the write→read hazard, so WB-to-ID needs no stall.
- stall is combinational in Ins, ex_dest and ex_mem_read only. It has no path from W_* or flush into the register update other than the priority rule.
- A load-use pair costs exactly one bubble. Back-to-back lw→lw→use stalls only when the immediately preceding ID/EX entry is the load.
- Reset asserted mid-stall clears stall immediately and asynchronously.

## Test plan
- Reset: assert RST asynchronously mid-cycle → all outputs 0 at once; after release, add $t1,$t2,$t3 decodes to alu_op=000, reg_write=1, dest=9.
- Write-back bypass: W_en=1, W_addr=10, W_data=0x1234 in the same cycle as Ins=add $t1,$t2,$t3 → rs_data=0x1234 after the edge; a subsequent read of $t2 returns 0x1234.
- Register 0: W_en=1, W_addr=0, W_data=0xFFFF, then read rs=0 → rs_data=0.
- Load-use: lw $s1,4($s2), then add $t1,$s1,$t3 → stall=1 for one cycle with a bubble in ID/EX; the add decodes on the next cycle with stall=0.
- Flush vs stall: set up a load-use condition with flush=1 → stall=0, bubble loaded, branch=0, reg_write=0.
- Branch target and illegal: beq with nextPC=0x100 and imm=0xFFFF → br_target=0xFC, alu_op=001. Opcode 111111 → illegal=1 with all control 0.

Source files
------------

// File: rtl/id_stage.sv
// MIPS decode stage: control decode, register file with write-back bypass, immediate/branch-target generation, load-use hazard detection.
// Latency 1 cycle into the ID/EX register; stall is combinational and a stall or flush loads a bubble instead of the decode.
module id_stage #(
    parameter int REG_COUNT = 32,
    parameter int DATA_W    = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] Ins,
    input  logic [DATA_W-1:0] nextPC,
    input  logic              flush,
    input  logic              W_en,
    input  logic [4:0]        W_addr,
    input  logic [DATA_W-1:0] W_data,
    output logic              stall,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] imm_ext,
    output logic [DATA_W-1:0] br_target,
    output logic [4:0]        dest,
    output logic [DATA_W-1:0] pc4_out,
    output logic [2:0]        alu_op,
    output logic              alu_src,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              branch,
    output logic              illegal
);
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    logic [DATA_W-1:0] r_regs [REG_COUNT];

    logic [5:0]        w_opcode;
    logic [5:0]        w_funct;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic [2:0]        w_alu_op;
    logic              w_alu_src;
    logic              w_reg_write;
    logic              w_mem_read;
    logic              w_mem_write;
    logic              w_branch;
    logic              w_illegal;
    logic [4:0]        w_dest;
    logic              w_uses_rt;
    logic              w_bubble;

    assign w_opcode = Ins[31:26];
    assign w_funct  = Ins[5:0];
    assign w_rs     = Ins[25:21];
    assign w_rt     = Ins[20:16];
    assign w_rd     = Ins[15:11];
    assign w_imm    = {{(DATA_W-16){Ins[15]}}, Ins[15:0]};

    always_comb begin
        w_alu_op    = ALU_ADD;
        w_alu_src   = 1'b0;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_branch    = 1'b0;
        w_illegal   = 1'b0;
        w_dest      = 5'd0;
        w_uses_rt   = 1'b0;
        case (w_opcode)
            6'b000000: begin
                w_uses_rt   = 1'b1;
                w_reg_write = 1'b1;
                w_dest      = w_rd;
                case (w_funct)
                    6'b100000: w_alu_op = ALU_ADD;
                    6'b100010: w_alu_op = ALU_SUB;
                    6'b100100: w_alu_op = ALU_AND;
                    6'b100101: w_alu_op = ALU_OR;
                    6'b101010: w_alu_op = ALU_SLT;
                    default: begin
                        w_reg_write = 1'b0;
                        w_dest      = 5'd0;
                        w_illegal   = 1'b1;
                    end
                endcase
            end
            6'b001000: begin
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
                w_dest      = w_rt;
            end
            6'b100011: begin
                w_alu_src   = 1'b1;
                w_mem_read  = 1'b1;
                w_reg_write = 1'b1;
                w_dest      = w_rt;
            end
            6'b101011: begin
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
                w_uses_rt   = 1'b1;
            end
            6'b000100: begin
                w_branch    = 1'b1;
                w_alu_op    = ALU_SUB;
                w_uses_rt   = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Operands see this edge's write-back so WB-to-ID never needs a stall.
    assign w_rs_val = (w_rs == 5'd0) ? '0 :
                      (W_en && W_addr == w_rs) ? W_data : r_regs[w_rs];
    assign w_rt_val = (w_rt == 5'd0) ? '0 :
                      (W_en && W_addr == w_rt) ? W_data : r_regs[w_rt];

    assign stall = !flush && mem_read && (dest != 5'd0) &&
                   ((dest == w_rs) || (dest == w_rt && w_uses_rt));
    assign w_bubble = flush || stall;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
        end else if (W_en && W_addr != 5'd0) begin
            r_regs[W_addr] <= W_data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rs_data   <= '0;
            rt_data   <= '0;
            imm_ext   <= '0;
            br_target <= '0;
            pc4_out   <= '0;
            dest      <= 5'd0;
            alu_op    <= ALU_ADD;
            alu_src   <= 1'b0;
            reg_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            branch    <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            rs_data   <= w_rs_val;
            rt_data   <= w_rt_val;
            imm_ext   <= w_imm;
            br_target <= nextPC + (w_imm << 2);
            pc4_out   <= nextPC;
            if (w_bubble) begin
                dest      <= 5'd0;
                alu_op    <= ALU_ADD;
                alu_src   <= 1'b0;
                reg_write <= 1'b0;
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
                branch    <= 1'b0;
                illegal   <= 1'b0;
            end else begin
                dest      <= w_dest;
                alu_op    <= w_alu_op;
                alu_src   <= w_alu_src;
                reg_write <= w_reg_write;
                mem_read  <= w_mem_read;
                mem_write <= w_mem_write;
                branch    <= w_branch;
                illegal   <= w_illegal;
            end
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus randomized instruction streams against a table-driven reference model.
module tb_id_stage;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] Ins = '0, nextPC = '0, W_data = '0;
    logic        flush = 1'b0, W_en = 1'b0;
    logic [4:0]  W_addr = '0;
    logic        stall;
    logic [31:0] rs_data, rt_data, imm_ext, br_target, pc4_out;
    logic [4:0]  dest;
    logic [2:0]  alu_op;
    logic        alu_src, reg_write, mem_read, mem_write, branch, illegal;

    id_stage #(.REG_COUNT(32), .DATA_W(32)) dut (
        .CLK(CLK), .RST(RST), .Ins(Ins), .nextPC(nextPC), .flush(flush),
        .W_en(W_en), .W_addr(W_addr), .W_data(W_data), .stall(stall),
        .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext), .br_target(br_target),
        .dest(dest), .pc4_out(pc4_out), .alu_op(alu_op), .alu_src(alu_src),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .illegal(illegal));

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0] op;
        logic       src, rw, mr, mw, br, ill;
        logic [4:0] dst;
    } ctl_t;

    int          n_checks = 0, n_errors = 0;
    logic [31:0] mreg [32];
    ctl_t        exp_ctl;
    logic [31:0] exp_rs, exp_rt, exp_imm, exp_br, exp_pc4;
    logic        exp_bubble;
    logic        stall_seen, stall_pred;

    function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] opc, input int rs, input int rt, input logic [15:0] imm);
        return {opc, rs[4:0], rt[4:0], imm};
    endfunction

    function automatic ctl_t ref_decode(input logic [31:0] ins);
        ctl_t c = '0;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20: begin c.rw = 1; c.dst = ins[15:11]; c.op = 3'd0; end
                6'h22: begin c.rw = 1; c.dst = ins[15:11]; c.op = 3'd1; end
                6'h24: begin c.rw = 1; c.dst = ins[15:11]; c.op = 3'd2; end
                6'h25: begin c.rw = 1; c.dst = ins[15:11]; c.op = 3'd3; end
                6'h2A: begin c.rw = 1; c.dst = ins[15:11]; c.op = 3'd4; end
                default: c.ill = 1;
            endcase
            6'h08: begin c.src = 1; c.rw = 1; c.dst = ins[20:16]; end
            6'h23: begin c.src = 1; c.mr = 1; c.rw = 1; c.dst = ins[20:16]; end
            6'h2B: begin c.src = 1; c.mw = 1; end
            6'h04: begin c.br = 1; c.op = 3'd1; end
            default: c.ill = 1;
        endcase
        return c;
    endfunction

    function automatic logic ref_stall(input logic [31:0] ins, input logic f);
        logic uses_rt = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h2B) || (ins[31:26] == 6'h04);
        if (f || !exp_ctl.mr || exp_ctl.dst == 0) return 1'b0;
        return (exp_ctl.dst == ins[25:21]) || (uses_rt && exp_ctl.dst == ins[20:16]);
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we, input logic [4:0] wa, input logic [31:0] wd);
        if (a == 0) return 32'd0;
        if (we && wa == a) return wd;
        return mreg[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        exp_ctl = '0; exp_rs = '0; exp_rt = '0; exp_imm = '0; exp_br = '0; exp_pc4 = '0;
        exp_bubble = 1'b0;
    endtask

    // One pipeline cycle: inputs at negedge, stall sampled mid-cycle, model advanced at the edge.
    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic f,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        @(negedge CLK);
        Ins = ins; nextPC = pc; flush = f; W_en = we; W_addr = wa; W_data = wd;
        #1;
        stall_seen = stall;
        stall_pred = ref_stall(ins, f);
        @(posedge CLK);
        exp_rs     = ref_read(ins[25:21], we, wa, wd);
        exp_rt     = ref_read(ins[20:16], we, wa, wd);
        exp_imm    = {{16{ins[15]}}, ins[15:0]};
        exp_br     = pc + exp_imm * 32'd4;
        exp_pc4    = pc;
        exp_bubble = f || stall_pred;
        exp_ctl    = exp_bubble ? ctl_t'('0) : ref_decode(ins);
        if (we && wa != 0) mreg[wa] = wd;
        #1;
        W_en = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] all_out;
        @(negedge CLK);
        n_checks++;
        all_out = rs_data | rt_data | imm_ext | br_target | pc4_out | {27'd0, dest} |
                  {29'd0, alu_op} | {26'd0, alu_src, reg_write, mem_read, mem_write, branch, illegal};
        if (all_out !== 0 || stall !== 1'b0) begin
            n_errors++; $display("FAIL reset_init or=%h stall=%b required 0/0", all_out, stall);
        end
        RST = 1'b0;
        model_reset();
        drive(32'h0, 32'h4, 0, 1, 5'd18, 32'hAAAA_5555);
        drive(i_type(6'h23, 18, 17, 16'd4), 32'h8, 0, 1, 5'd11, 32'h0000_0777);
        @(negedge CLK);
        Ins = r_type(17, 11, 9, 6'h20); nextPC = 32'hC;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_errors++; $display("FAIL reset_prestall stall=%b required 1", stall); end
        #1 RST = 1'b1;
        #1;
        n_checks++;
        all_out = rs_data | rt_data | imm_ext | br_target | pc4_out | {27'd0, dest} |
                  {29'd0, alu_op} | {26'd0, alu_src, reg_write, mem_read, mem_write, branch, illegal};
        if (all_out !== 0 || stall !== 1'b0) begin
            n_errors++; $display("FAIL reset_async or=%h stall=%b required 0/0", all_out, stall);
        end
        model_reset();
        @(negedge CLK) RST = 1'b0;
        drive(r_type(10, 11, 9, 6'h20), 32'h10, 0, 0, 0, 0);
        n_checks++;
        if (alu_op !== 3'b000 || reg_write !== 1'b1 || dest !== 5'd9) begin
            n_errors++; $display("FAIL reset_add op=%b rw=%b dest=%0d required 000/1/9", alu_op, reg_write, dest);
        end
        n_checks++;
        if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
            n_errors++; $display("FAIL reset_rf rs=%h rt=%h required 0/0", rs_data, rt_data);
        end
    endtask

    task automatic test_bypass();
        drive(r_type(10, 11, 9, 6'h20), 32'h20, 0, 1, 5'd10, 32'h1234);
        n_checks++;
        if (rs_data !== 32'h1234) begin n_errors++; $display("FAIL bypass_same rs=%h required 00001234", rs_data); end
        drive(r_type(10, 11, 9, 6'h20), 32'h24, 0, 0, 0, 0);
        n_checks++;
        if (rs_data !== 32'h1234) begin n_errors++; $display("FAIL bypass_later rs=%h required 00001234", rs_data); end
    endtask

    task automatic test_reg0();
        drive(r_type(0, 0, 9, 6'h20), 32'h30, 0, 1, 5'd0, 32'hFFFF);
        n_checks++;
        if (rs_data !== 32'd0) begin n_errors++; $display("FAIL reg0_bypass rs=%h required 0", rs_data); end
        drive(r_type(0, 10, 9, 6'h20), 32'h34, 0, 0, 0, 0);
        n_checks++;
        if (rs_data !== 32'd0 || rt_data !== 32'h1234) begin
            n_errors++; $display("FAIL reg0_read rs=%h rt=%h required 0/1234", rs_data, rt_data);
        end
    endtask

    task automatic test_load_use();
        drive(i_type(6'h23, 18, 17, 16'd4), 32'h40, 0, 0, 0, 0);
        drive(r_type(17, 11, 9, 6'h20), 32'h44, 0, 0, 0, 0);
        n_checks++;
        if (stall_seen !== 1'b1) begin n_errors++; $display("FAIL loaduse_stall stall=%b required 1", stall_seen); end
        n_checks++;
        if (reg_write !== 1'b0 || dest !== 5'd0 || mem_read !== 1'b0) begin
            n_errors++; $display("FAIL loaduse_bubble rw=%b dest=%0d mr=%b required 0/0/0", reg_write, dest, mem_read);
        end
        drive(r_type(17, 11, 9, 6'h20), 32'h44, 0, 0, 0, 0);
        n_checks++;
        if (stall_seen !== 1'b0 || reg_write !== 1'b1 || dest !== 5'd9) begin
            n_errors++; $display("FAIL loaduse_retry stall=%b rw=%b dest=%0d required 0/1/9", stall_seen, reg_write, dest);
        end
    endtask

    task automatic test_flush();
        drive(i_type(6'h23, 18, 17, 16'd4), 32'h50, 0, 0, 0, 0);
        drive(i_type(6'h04, 17, 11, 16'd2), 32'h54, 1, 0, 0, 0);
        n_checks++;
        if (stall_seen !== 1'b0) begin n_errors++; $display("FAIL flush_stall stall=%b required 0", stall_seen); end
        n_checks++;
        if (branch !== 1'b0 || reg_write !== 1'b0 || dest !== 5'd0 || illegal !== 1'b0) begin
            n_errors++; $display("FAIL flush_bubble br=%b rw=%b dest=%0d ill=%b required 0/0/0/0", branch, reg_write, dest, illegal);
        end
    endtask

    task automatic test_branch_illegal();
        drive(i_type(6'h04, 1, 2, 16'hFFFF), 32'h100, 0, 0, 0, 0);
        n_checks++;
        if (br_target !== 32'hFC || alu_op !== 3'b001 || branch !== 1'b1) begin
            n_errors++; $display("FAIL beq tgt=%h op=%b br=%b required 000000fc/001/1", br_target, alu_op, branch);
        end
        drive(32'hFC00_0000, 32'h104, 0, 0, 0, 0);
        n_checks++;
        if (illegal !== 1'b1 || {alu_src, reg_write, mem_read, mem_write, branch} !== 5'd0 || dest !== 5'd0 || alu_op !== 3'd0) begin
            n_errors++; $display("FAIL illegal ill=%b ctl=%b dest=%0d op=%b required 1/00000/0/000",
                                 illegal, {alu_src, reg_write, mem_read, mem_write, branch}, dest, alu_op);
        end
    endtask

    function automatic logic [31:0] rand_ins();
        logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
        int rs = $urandom_range(0, 4), rt = $urandom_range(0, 4), rd = $urandom_range(0, 4);
        logic [15:0] imm = 16'($urandom);
        case ($urandom_range(0, 8))
            0, 1:    return r_type(rs, rt, rd, fns[$urandom_range(0, 5)]);
            2:       return i_type(6'h08, rs, rt, imm);
            3, 4:    return i_type(6'h23, rs, rt, imm);
            5:       return i_type(6'h2B, rs, rt, imm);
            6:       return i_type(6'h04, rs, rt, imm);
            7:       return r_type(rs, rt, rd, 6'($urandom));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] ins = 32'h0, pc = 32'h0;
        logic        hold = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!hold) begin ins = rand_ins(); pc = $urandom; end
            drive(ins, pc, ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1),
                  5'($urandom_range(0, 5)), $urandom);
            hold = stall_pred;
            n_checks++;
            if (stall_seen !== stall_pred) begin
                n_errors++; $display("FAIL rand_stall cyc=%0d stall=%b required %b", cyc, stall_seen, stall_pred);
            end
            n_checks++;
            if ({alu_op, alu_src, reg_write, mem_read, mem_write, branch, illegal, dest} !== exp_ctl) begin
                n_errors++; $display("FAIL rand_ctl cyc=%0d ctl=%h required %h", cyc,
                    {alu_op, alu_src, reg_write, mem_read, mem_write, branch, illegal, dest}, exp_ctl);
            end
            if (!exp_bubble) begin
                n_checks++;
                if ({rs_data, rt_data, imm_ext, br_target, pc4_out} !== {exp_rs, exp_rt, exp_imm, exp_br, exp_pc4}) begin
                    n_errors++; $display("FAIL rand_data cyc=%0d got=%h required %h", cyc,
                        {rs_data, rt_data, imm_ext, br_target, pc4_out}, {exp_rs, exp_rt, exp_imm, exp_br, exp_pc4});
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        model_reset();
        stall_seen = 1'b0; stall_pred = 1'b0;
        repeat (2) @(posedge CLK);
        test_reset();
        test_bypass();
        test_reg0();
        test_load_use();
        test_flush();
        test_branch_illegal();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
